// File: rtl/vga_sync_decoder.sv
// Recovers active-pixel coordinates, data-enable and lock status from a sampled VGA stream,
// and accumulates a per-frame r+g+b checksum; outputs trail the input pins by two clocks.
module vga_sync_decoder #(
  parameter int   H_ACTIVE    = 1440,
  parameter int   H_FP        = 80,
  parameter int   H_SYNC      = 152,
  parameter int   H_BP        = 232,
  parameter int   V_ACTIVE    = 900,
  parameter int   V_FP        = 1,
  parameter int   V_SYNC      = 3,
  parameter int   V_BP        = 28,
  parameter logic HS_POL      = 1'b0,
  parameter logic VS_POL      = 1'b1,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  pix_r,
  input  logic [3:0]  pix_g,
  input  logic [3:0]  pix_b,
  output logic [10:0] rx_x,
  output logic [10:0] rx_y,
  output logic        rx_de,
  output logic [3:0]  rx_r,
  output logic [3:0]  rx_g,
  output logic [3:0]  rx_b,
  output logic        frame_start,
  output logic [23:0] frame_sum,
  output logic        frame_sum_vld,
  output logic        locked,
  output logic        sync_err
);

  localparam int          H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int          V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [10:0] H_FIRST    = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_LAST     = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [10:0] V_FIRST    = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_LAST     = 11'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [10:0] H_END_CNT  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_END_CNT  = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_WIDTH    = 11'(H_SYNC);
  localparam logic [10:0] V_WIDTH    = 11'(V_SYNC);
  localparam logic [10:0] CNT_MAX    = 11'h7ff;

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_LOCKED} state_t;

  logic        hs1, vs1, hs_act_q, vs_act_q;
  logic [3:0]  r1, g1, b1;
  logic        hs_act, vs_act, h_edge, v_edge;
  logic [10:0] h_cnt, v_cnt, hs_w, vs_w;
  logic [10:0] h_nxt, v_nxt, hs_w_nxt, vs_w_nxt;
  logic        line_bad, frame_bad, timeout, viol, in_act, de_nxt, lock_nxt;
  logic [5:0]  pix_sum;
  logic [23:0] acc, acc_nxt;
  state_t      state, state_nxt;
  logic [3:0]  gcnt, gcnt_nxt;
  logic        err_nxt;

  // Sync registers reset to their inactive level so release never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs1      <= ~HS_POL;
      vs1      <= ~VS_POL;
      r1       <= '0;
      g1       <= '0;
      b1       <= '0;
      hs_act_q <= 1'b0;
      vs_act_q <= 1'b0;
    end else begin
      hs1      <= hsync;
      vs1      <= vsync;
      r1       <= pix_r;
      g1       <= pix_g;
      b1       <= pix_b;
      hs_act_q <= hs_act;
      vs_act_q <= vs_act;
    end
  end

  assign hs_act = (hs1 == HS_POL);
  assign vs_act = (vs1 == VS_POL);
  assign h_edge = hs_act & ~hs_act_q;
  assign v_edge = vs_act & ~vs_act_q;

  // *_nxt are the coordinates of the sample now in stage 1.
  always_comb begin
    h_nxt    = h_edge ? 11'd0 : (h_cnt == CNT_MAX) ? h_cnt : h_cnt + 11'd1;
    v_nxt    = v_edge ? 11'd0 : (h_edge && v_cnt != CNT_MAX) ? v_cnt + 11'd1 : v_cnt;
    hs_w_nxt = h_edge ? 11'd1 : (hs_act && hs_w != CNT_MAX) ? hs_w + 11'd1 : hs_w;
    if (v_edge)
      vs_w_nxt = h_edge ? 11'd1 : 11'd0;
    else if (h_edge && vs_act && vs_w != CNT_MAX)
      vs_w_nxt = vs_w + 11'd1;
    else
      vs_w_nxt = vs_w;
  end

  assign line_bad  = h_edge & ((h_cnt != H_END_CNT) | (hs_w != H_WIDTH));
  assign frame_bad = v_edge & (~h_edge | (v_cnt != V_END_CNT) | (vs_w != V_WIDTH));
  assign timeout   = (h_nxt == CNT_MAX) & (h_cnt != CNT_MAX);
  assign viol      = line_bad | frame_bad | timeout;

  assign in_act  = (h_nxt >= H_FIRST) && (h_nxt <= H_LAST) && (v_nxt >= V_FIRST) && (v_nxt <= V_LAST);
  assign pix_sum = 6'(r1) + 6'(g1) + 6'(b1);
  assign acc_nxt = v_edge ? 24'd0 : in_act ? acc + 24'(pix_sum) : acc;

  always_comb begin
    state_nxt = state;
    gcnt_nxt  = gcnt;
    err_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (v_edge) begin
          state_nxt = S_TRACK;
          gcnt_nxt  = 4'd0;
        end
      end
      S_TRACK: begin
        if (viol) begin
          gcnt_nxt = 4'd0;
        end else if (v_edge) begin
          if (gcnt + 4'd1 == 4'(LOCK_FRAMES)) begin
            state_nxt = S_LOCKED;
            gcnt_nxt  = 4'd0;
          end else begin
            gcnt_nxt = gcnt + 4'd1;
          end
        end
      end
      S_LOCKED: begin
        if (viol) begin
          state_nxt = S_TRACK;
          gcnt_nxt  = 4'd0;
          err_nxt   = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign lock_nxt = (state_nxt == S_LOCKED);
  assign de_nxt   = in_act & lock_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt         <= '0;
      v_cnt         <= '0;
      hs_w          <= '0;
      vs_w          <= '0;
      acc           <= '0;
      state         <= S_IDLE;
      gcnt          <= '0;
      rx_x          <= '0;
      rx_y          <= '0;
      rx_de         <= 1'b0;
      rx_r          <= '0;
      rx_g          <= '0;
      rx_b          <= '0;
      frame_start   <= 1'b0;
      frame_sum     <= '0;
      frame_sum_vld <= 1'b0;
      locked        <= 1'b0;
      sync_err      <= 1'b0;
    end else begin
      h_cnt         <= h_nxt;
      v_cnt         <= v_nxt;
      hs_w          <= hs_w_nxt;
      vs_w          <= vs_w_nxt;
      acc           <= acc_nxt;
      state         <= state_nxt;
      gcnt          <= gcnt_nxt;
      rx_de         <= de_nxt;
      rx_x          <= de_nxt ? h_nxt - H_FIRST : 11'd0;
      rx_y          <= de_nxt ? v_nxt - V_FIRST : 11'd0;
      rx_r          <= de_nxt ? r1 : 4'd0;
      rx_g          <= de_nxt ? g1 : 4'd0;
      rx_b          <= de_nxt ? b1 : 4'd0;
      frame_start   <= de_nxt && (h_nxt == H_FIRST) && (v_nxt == V_FIRST);
      locked        <= lock_nxt;
      sync_err      <= err_nxt;
      frame_sum_vld <= v_edge & ~viol & lock_nxt;
      if (v_edge && !viol && lock_nxt)
        frame_sum <= acc;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Drives frame-structured VGA streams with small timing parameters and compares every output
// cycle against a frame-level reference model.
module tb_vga_sync_decoder;

  localparam int   H_ACTIVE = 8, H_FP = 2, H_SYNC = 2, H_BP = 2;
  localparam int   V_ACTIVE = 4, V_FP = 1, V_SYNC = 1, V_BP = 1;
  localparam logic HS_POL = 1'b0, VS_POL = 1'b1;
  localparam int   LOCK_FRAMES = 2;
  localparam int   H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int   HF = H_SYNC + H_BP, HL = HF + H_ACTIVE - 1;
  localparam int   VF = V_SYNC + V_BP, VL = VF + V_ACTIVE - 1;
  localparam int   K_NOM = 0, K_SHORT = 1, K_OFF = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsync = ~HS_POL, vsync = ~VS_POL;
  logic [3:0]  pix_r = '0, pix_g = '0, pix_b = '0;
  logic [10:0] rx_x, rx_y;
  logic        rx_de, frame_start, frame_sum_vld, locked, sync_err;
  logic [3:0]  rx_r, rx_g, rx_b;
  logic [23:0] frame_sum;

  vga_sync_decoder #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .rx_x(rx_x), .rx_y(rx_y), .rx_de(rx_de), .rx_r(rx_r), .rx_g(rx_g), .rx_b(rx_b),
    .frame_start(frame_start), .frame_sum(frame_sum), .frame_sum_vld(frame_sum_vld),
    .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        de;
    logic [10:0] x;
    logic [10:0] y;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        fs;
    logic [23:0] sum;
    logic        vld;
    logic        lk;
    logic        err;
  } exp_t;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t prev_e = '0;
  exp_t obs;

  // Frame-level reference state: lock follows the run of well-formed frames since the last fault.
  bit          m_seen = 0, m_locked = 0, m_prev_ok = 0;
  int          streak = 0;
  logic [23:0] m_acc = '0, m_sum = '0;

  task automatic check(input string tag);
    obs = {rx_de, rx_x, rx_y, rx_r, rx_g, rx_b, frame_start, frame_sum, frame_sum_vld, locked, sync_err};
    vectors++;
    assert (obs === prev_e)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, prev_e);
    end
  endtask

  task automatic step(input bit hs_a, input bit vs_a, input int cr, input int cg, input int cb,
                      input exp_t e, input string tag);
    hsync = hs_a ? HS_POL : ~HS_POL;
    vsync = vs_a ? VS_POL : ~VS_POL;
    pix_r = 4'(cr);
    pix_g = 4'(cg);
    pix_b = 4'(cb);
    @(posedge clk);
    @(negedge clk);
    check(tag);
    prev_e = e;
  endtask

  task automatic sample(input bit hs_a, input bit vs_a, input bit edge_here, input bit edge_ok,
                        input bit tmo, input bit act, input int x, input int y,
                        input int cmode, input string tag);
    exp_t e;
    int   cr, cg, cb;
    e  = '0;
    cr = (cmode == 1) ? 15 : $urandom_range(0, 15);
    cg = (cmode == 1) ? 15 : $urandom_range(0, 15);
    cb = (cmode == 1) ? 15 : $urandom_range(0, 15);
    if (edge_here) begin
      if (!m_seen) begin
        m_seen = 1;
        streak = 0;
      end else if (edge_ok) begin
        streak++;
        if (streak >= LOCK_FRAMES) begin
          m_locked = 1;
          m_sum    = m_acc;
          e.vld    = 1'b1;
        end
      end else begin
        e.err    = m_locked;
        m_locked = 0;
        streak   = 0;
      end
      m_acc = '0;
    end
    if (tmo) begin
      e.err    = m_locked;
      m_locked = 0;
      streak   = 0;
    end
    if (act) m_acc = m_acc + 24'(cr + cg + cb);
    e.de = act && m_locked;
    if (e.de) begin
      e.x = 11'(x);
      e.y = 11'(y);
      e.r = 4'(cr);
      e.g = 4'(cg);
      e.b = 4'(cb);
      e.fs = (x == 0) && (y == 0);
    end
    e.sum = m_sum;
    e.lk  = m_locked;
    step(hs_a, vs_a, cr, cg, cb, e, tag);
  endtask

  task automatic send_frame(input int kind, input int first_line, input int last_line,
                            input int cmode, input string tag);
    for (int l = first_line; l <= last_line; l++) begin
      int per;
      per = (kind == K_SHORT && l == V_TOTAL - 1) ? H_TOTAL - 1 : H_TOTAL;
      for (int p = 0; p < per; p++) begin
        bit vs_a, edge_here, eok, act;
        if (kind == K_OFF) begin
          vs_a      = (l < V_SYNC && !(l == 0 && p == 0)) || (l == V_SYNC && p == 0);
          edge_here = (l == 0 && p == 1);
          eok       = 0;
        end else begin
          vs_a      = (l < V_SYNC);
          edge_here = (l == 0 && p == 0);
          eok       = m_prev_ok;
        end
        act = (l >= VF) && (l <= VL) && (p >= HF) && (p <= HL);
        sample(p < H_SYNC, vs_a, edge_here, eok, 0, act, p - HF, l - VF, cmode, tag);
      end
    end
    m_prev_ok = (first_line == 0) && (last_line == V_TOTAL - 1) && (kind == K_NOM);
  endtask

  task automatic reset_hold(input int n);
    rst_n  = 1'b0;
    prev_e = '0;
    m_seen = 0; m_locked = 0; m_prev_ok = 0; streak = 0; m_acc = '0; m_sum = '0;
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 15), '0, "reset_zero");
    rst_n = 1'b1;
  endtask

  initial begin
    reset_hold(40);

    send_frame(K_NOM, 3, V_TOTAL - 1, 0, "pre_vsync_partial");
    send_frame(K_NOM, 0, V_TOTAL - 1, 0, "track_frame1");
    send_frame(K_NOM, 0, V_TOTAL - 1, 0, "track_frame2");
    send_frame(K_NOM, 0, V_TOTAL - 1, 0, "locked_random");
    send_frame(K_NOM, 0, V_TOTAL - 1, 1, "locked_white");
    send_frame(K_NOM, 0, V_TOTAL - 1, 0, "white_sum_1440");

    send_frame(K_SHORT, 0, V_TOTAL - 1, 0, "short_last_line");
    send_frame(K_NOM, 0, V_TOTAL - 1, 0, "short_line_err");
    send_frame(K_NOM, 0, V_TOTAL - 1, 0, "relock_frame1");
    send_frame(K_NOM, 0, V_TOTAL - 1, 1, "relock_frame2");

    send_frame(K_NOM, 0, 3, 0, "before_mid_reset");
    reset_hold(5);
    send_frame(K_NOM, 4, V_TOTAL - 1, 0, "post_reset_partial");
    send_frame(K_NOM, 0, V_TOTAL - 1, 0, "post_reset_track1");
    send_frame(K_NOM, 0, V_TOTAL - 1, 0, "post_reset_track2");
    send_frame(K_NOM, 0, V_TOTAL - 1, 0, "post_reset_locked");

    sample(1, 1, 1, m_prev_ok, 0, 0, 0, 0, 0, "hsync_stop_edge");
    for (int k = 1; k <= 2060; k++)
      sample(0, 1, 0, 0, k == 2047, 0, 0, 0, 0, "hsync_timeout");

    reset_hold(5);
    for (int f = 0; f < 5; f++)
      send_frame(K_OFF, 0, V_TOTAL - 1, 0, "vsync_offset");
    send_frame(K_NOM, 0, 1, 0, "after_offset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
